// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - parametrised up/down modulo counter with wrap pulse and sticky overflow
module counter_updown_mod #(
  parameter int              WIDTH     = 8,
  parameter bit              SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_load_clamped = (load_val > limit) ? limit : load_val;

  // Increment/decrement are only selected away from the boundary, so no
  // result ever depends on binary roll-over of the WIDTH-bit adder.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf & ~ovf_clr;
    if (clr) begin
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (en) begin
      if (r_count > limit) begin
        w_count_nxt = limit;
      end else if (up) begin
        if (r_count < limit) begin
          w_count_nxt = r_count + 1'b1;
        end else if (SATURATE) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end
      end else begin
        if (r_count != '0) begin
          w_count_nxt = r_count - 1'b1;
        end else if (SATURATE) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_count_nxt = limit;
          w_wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= RESET_VAL;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - directed self-checking bench for counter_updown_mod
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en, up, clr, load, ovf_clr;
  logic [7:0] load_val, limit;

  logic [7:0] c0, c1, c2;
  logic       w0, w1, w2, o0, o1, o2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'd0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .ovf_clr(ovf_clr),
    .count(c0), .wrap(w0), .ovf(o0));

  counter_updown_mod #(.WIDTH(8), .SATURATE(1'b1), .RESET_VAL(8'd0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .ovf_clr(ovf_clr),
    .count(c1), .wrap(w1), .ovf(o1));

  counter_updown_mod #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'd3)) u_rv3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .ovf_clr(ovf_clr),
    .count(c2), .wrap(w2), .ovf(o2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 0; up = 1; clr = 0; load = 0; ovf_clr = 0;
    load_val = 8'd0; limit = 8'd255;

    #1 reset = 1'b0;
    #2;
    check("rst_count0", c0, 0);
    check("rst_wrap0", w0, 0);
    check("rst_ovf0", o0, 0);
    check("rst_count_rv3", c2, 3);
    step();
    step();
    check("rst_hold_rv3", c2, 3);
    reset = 1'b1;

    // full binary sequence with wrap on return to 0
    en = 1; up = 1; limit = 8'd255;
    for (int i = 1; i <= 256; i++) begin
      step();
      check("full_count", c0, i % 256);
      check("full_wrap", w0, (i == 256) ? 1 : 0);
      check("full_ovf", o0, 0);
    end
    check("full_sat_ovf", o1, 1);
    check("full_sat_hold", c1, 255);

    // modulo-10 down count
    en = 0; load = 1; load_val = 8'd2; limit = 8'd9;
    step();
    check("mod_load", c0, 2);
    load = 0; en = 1; up = 0;
    step(); check("mod_c1", c0, 1); check("mod_w1", w0, 0);
    step(); check("mod_c0", c0, 0); check("mod_w0", w0, 0);
    step(); check("mod_c9", c0, 9); check("mod_w9", w0, 1);
    step(); check("mod_c8", c0, 8); check("mod_w8", w0, 0);

    // saturation and sticky ovf
    en = 0; clr = 1;
    step();
    check("clr_count", c1, 0); check("clr_ovf", o1, 0);
    clr = 0; load = 1; load_val = 8'd4; limit = 8'd5;
    step();
    check("sat_load", c1, 4);
    load = 0; en = 1; up = 1;
    step(); check("sat_c5a", c1, 5); check("sat_o_a", o1, 0);
    step(); check("sat_c5b", c1, 5); check("sat_o_b", o1, 1); check("sat_nowrap", w1, 0);
    step(); check("sat_c5c", c1, 5); check("sat_o_c", o1, 1);
    ovf_clr = 1;
    step(); check("sat_setwins", o1, 1); check("sat_c5d", c1, 5);
    en = 0;
    step(); check("sat_ovfclr", o1, 0);
    ovf_clr = 0;

    // priority and clamp
    clr = 1; load = 1; en = 1; load_val = 8'd7; limit = 8'd50;
    step(); check("prio_clr", c0, 0);
    clr = 0; load = 1; en = 0; load_val = 8'd200;
    step(); check("load_clamp", c0, 50);
    load = 0; limit = 8'd20; en = 1; up = 0;
    step(); check("oor_clamp", c0, 20); check("oor_nowrap", w0, 0);
    step(); check("oor_next", c0, 19);

    // async reset while wrap/ovf are set
    up = 1;
    step(); check("pre_c20", c2, 20);
    step(); check("pre_wrap", w2, 1); check("pre_c0", c2, 0); check("pre_ovf", o1, 1);
    #2 reset = 1'b0;
    #1;
    check("async_count", c2, 3);
    check("async_wrap", w2, 0);
    check("async_wrap0", w0, 0);
    check("async_ovf", o1, 0);
    step();
    check("async_hold", c2, 3);
    reset = 1'b1;
    step();
    check("resume_rv3", c2, 4);
    check("resume_c0", c0, 1);

    // degenerate limit == 0
    clr = 1;
    step();
    clr = 0; limit = 8'd0; en = 1;
    for (int i = 0; i < 4; i++) begin
      up = (i < 2);
      step();
      check("lim0_count", c0, 0);
      check("lim0_wrap", w0, 1);
      check("lim0_sat_count", c1, 0);
      check("lim0_sat_ovf", o1, 1);
      check("lim0_sat_wrap", w1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised up/down modulo counter. It is the next generation of the fixed 8-bit incrementing counter, with configurable width, a run-time programmable terminal value, direction control, synchronous load and clear, a wrap-or-saturate mode, a registered wrap pulse and a sticky overflow flag. It sits beside the datapath registers as a general event and timing counter and is mapped onto the standard flip-flop and adder cell library.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; minimum 2.
- SATURATE, 0, boundary mode: 0 = wrap at the boundary, 1 = hold at the boundary.
- RESET_VAL, 0, value `count` takes while `reset` is asserted; must be ≤ 2^WIDTH−1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; `reset`=0 is asserted.
- en  in  1  count enable; counter steps once per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when stepping.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of `load_val`.
- load_val  in  WIDTH  value to load.
- limit  in  WIDTH  terminal value; legal count range is 0..limit.
- ovf_clr  in  1  synchronous clear of `ovf`.
- count  out  WIDTH  current count, registered.
- wrap  out  1  registered, one-cycle pulse when a wrap occurred on the last edge.
- ovf  out  1  sticky flag; set when a step is blocked by saturation.

## Operation
- Per-edge priority: `clr` > `load` > `en` > hold.
- `clr`: count ← 0; wrap ← 0; ovf ← 0.
- `load`: count ← min(load_val, limit); wrap ← 0; ovf unchanged apart from `ovf_clr`.
- Out-of-range step (`en` with count > limit, e.g. `limit` lowered mid-run): count ← limit in either direction; no wrap and no ovf event.
- Normal step (`en` with count ≤ limit):
  - up, count < limit: count+1.
  - up, count == limit: SATURATE=0 → count ← 0, wrap ← 1. SATURATE=1 → hold, ovf ← 1.
  - down, count > 0: count−1.
  - down, count == 0: SATURATE=0 → count ← limit, wrap ← 1. SATURATE=1 → hold, ovf ← 1.
- Arithmetic is WIDTH bits and never relies on natural binary overflow. With limit = 2^WIDTH−1 the sequence is the full binary sequence, with explicit wrap detection.
- limit == 0: count stays 0. Every enabled step is a boundary event: wrap pulses every cycle (SATURATE=0) or ovf sets (SATURATE=1).
- ovf: set by a saturation event; cleared by `ovf_clr`, `clr` or reset. If `ovf_clr` and a saturation event occur on the same edge, set wins.
- wrap: high for exactly one cycle after each wrap edge, so it stays high continuously across consecutive wrap events. It is 0 after any non-wrap edge.

## Timing
- Reset (async, `reset`=0): count = RESET_VAL, wrap = 0, ovf = 0, applied immediately and held while asserted. Deassertion is synchronised externally; the first step occurs on the first rising edge with `reset`=1.
- Reset asserted mid-operation overrides any in-progress load, clear or step; no partial update.
- Latency: the effect of `en`, `up`, `clr`, `load`, `load_val`, `limit` and `ovf_clr` is visible on `count`, `wrap` and `ovf` one cycle after the sampling edge.
- All outputs are direct register outputs, with no combinational input-to-output path.
- `limit` and `load_val` may change on any cycle; the value sampled at the edge is used.

## Test plan
- Reset and wrap count: WIDTH=8, SATURATE=0, RESET_VAL=0, limit=255, en=1, up=1 from reset, 256 edges → count 0,1,…,255,0; wrap high only in the cycle count returns to 0; ovf stays 0.
- Modulo down-count: limit=9, load_val=2, load one cycle, then en=1, up=0 → count 2,1,0,9,8; wrap high with the 9.
- Saturation and ovf: SATURATE=1, limit=5, count=4, up steps → 5,5,5 and ovf=1 from the first hold. Then ovf_clr together with another blocked up step → ovf remains 1. Then ovf_clr with en=0 → ovf=0.
- Priority and clamp: clr=1, load=1, en=1 together → count 0. Then load=1, load_val=200, limit=50 → count 50. Lower limit to 20 with en=1, up=0 → count 20 on the next edge, no wrap.
- Async reset: RESET_VAL=3; pull `reset` low between edges mid-count → count=3, wrap=0, ovf=0 immediately, before the next edge. Release → counting resumes from 3.
- Degenerate limit: limit=0, en=1 for 4 cycles with SATURATE=0 → count 0 and wrap high for all 4 cycles. Same stimulus with SATURATE=1 → ovf=1 and wrap=0.
